// File: rtl/display_matrix_scanner_if.sv
// Frame-memory read port shared by the LED scan engine (master) and the memory arbiter (slave).
interface display_matrix_scanner_if #(
   parameter int RW = 3,
   parameter int CW = 3,
   parameter int CH = 2
);
   logic             mem_en;
   logic [RW+CW-1:0] mem_addr;
   logic             mem_valid;
   logic [CH-1:0]    mem_data;

   modport master (output mem_en, output mem_addr, input mem_valid, input mem_data);
   modport slave  (input mem_en, input mem_addr, output mem_valid, output mem_data);
endinterface

// File: rtl/display_matrix_scanner.sv
// LED-matrix scan engine: prefetches the next row into a shadow buffer with flicker patches
// applied, and swaps it onto the column drivers on each scan tick (blank + underrun if late).
module display_matrix_scanner #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int CH   = 2,
   parameter int RW   = $clog2(ROWS),
   parameter int CW   = $clog2(COLS),
   parameter int PCW  = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n_,
   input  logic                      en,
   input  logic                      scan_tick,
   input  logic                      flicker_state,
   input  logic                      screen_flicker_en,
   input  logic                      point_flicker_en,
   input  logic [RW+CW-1:0]          point_flicker_pos,
   input  logic [PCW-1:0]            point_flicker_ch,
   input  logic [CH-1:0]             chan_flicker_en,
   display_matrix_scanner_if.master  mem,
   output logic [ROWS-1:0]           led_row,
   output logic [CH*COLS-1:0]        led_col,
   output logic                      underrun
);
   typedef enum logic [1:0] {FETCH = 2'd0, GAP = 2'd1, DONE = 2'd2} state_t;

   state_t             state, state_nxt;
   logic [RW-1:0]      fetch_row, disp_row;
   logic [CW-1:0]      col_i;
   logic [CH*COLS-1:0] shadow, shadow_nxt;
   logic [CH-1:0]      pix;
   logic               row_on, active, store;

   function automatic logic [CH-1:0] patch_pixel(
      input logic [CH-1:0]  data,
      input logic           fs,
      input logic           scr_en,
      input logic           pt_hit,
      input logic [PCW-1:0] pt_ch,
      input logic [CH-1:0]  ch_mask
   );
      logic [CH-1:0] p;
      p = data;
      for (int k = 0; k < CH; k++) begin
         if (scr_en)
            p[k] = (k == 0) ? fs : ~fs;
         else if (pt_hit) begin
            if (PCW'(k) == pt_ch) p[k] = fs;
         end
         else if (ch_mask[k] && data[k])
            p[k] = fs;
      end
      return p;
   endfunction

   // A tick in the same cycle as mem_valid aborts the row, so that beat is dropped.
   assign store        = mem.mem_en && mem.mem_valid && !scan_tick;
   assign mem.mem_addr = {fetch_row, col_i};
   assign pix = patch_pixel(mem.mem_data, flicker_state, screen_flicker_en,
                            point_flicker_en && (point_flicker_pos == {fetch_row, col_i}),
                            point_flicker_ch, chan_flicker_en);

   always_comb begin
      shadow_nxt = shadow;
      for (int c = 0; c < COLS; c++) begin
         if (CW'(c) == col_i) begin
            for (int k = 0; k < CH; k++) shadow_nxt[k*COLS + c] = pix[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n_) begin
      if (!rst_n_)
         state <= FETCH;
      else if (!en)
         state <= FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (scan_tick)
         state_nxt = FETCH;
      else begin
         case (state)
            FETCH:   if (store) state_nxt = (col_i == CW'(COLS-1)) ? DONE : GAP;
            GAP:     state_nxt = FETCH;
            DONE:    state_nxt = DONE;
            default: state_nxt = FETCH;
         endcase
      end
   end

   // active holds requests off for the first cycle out of reset so mem_en reads 0 while in reset.
   always_comb begin
      mem.mem_en = 1'b0;
      if (active && state == FETCH) mem.mem_en = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n_) begin
      if (!rst_n_) begin
         active    <= 1'b0;
         row_on    <= 1'b0;
         disp_row  <= RW'(ROWS-1);
         fetch_row <= '0;
         col_i     <= '0;
         shadow    <= '0;
         led_col   <= '0;
         underrun  <= 1'b0;
      end
      else if (!en) begin
         active    <= 1'b0;
         row_on    <= 1'b0;
         disp_row  <= RW'(ROWS-1);
         fetch_row <= '0;
         col_i     <= '0;
         shadow    <= '0;
         led_col   <= '0;
         underrun  <= 1'b0;
      end
      else begin
         active   <= 1'b1;
         underrun <= 1'b0;
         if (scan_tick) begin
            row_on    <= 1'b1;
            disp_row  <= fetch_row;
            fetch_row <= fetch_row + 1'b1;
            col_i     <= '0;
            shadow    <= '0;
            if (state == DONE)
               led_col <= shadow;
            else begin
               led_col  <= '0;
               underrun <= 1'b1;
            end
         end
         else if (store) begin
            shadow <= shadow_nxt;
            col_i  <= col_i + 1'b1;
         end
      end
   end

   assign led_row = row_on ? (ROWS'(1) << disp_row) : '0;

endmodule

// File: tb/tb_display_matrix_scanner.sv
// Randomised bench for display_matrix_scanner against a transaction-level row/tick model.
module tb_display_matrix_scanner;
   localparam int ROWS = 8, COLS = 8, CH = 2, RW = 3, CW = 3, PCW = 1, LAT = 3;

   logic               clk = 1'b0;
   logic               rst_n_, en, scan_tick, flicker_state;
   logic               screen_flicker_en, point_flicker_en;
   logic [RW+CW-1:0]   point_flicker_pos;
   logic [PCW-1:0]     point_flicker_ch;
   logic [CH-1:0]      chan_flicker_en;
   logic [ROWS-1:0]    led_row;
   logic [CH*COLS-1:0] led_col;
   logic               underrun;

   int errors = 0, checks = 0;

   display_matrix_scanner_if #(.RW(RW), .CW(CW), .CH(CH)) mem_bus();

   display_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .CH(CH)) dut (
      .clk(clk), .rst_n_(rst_n_), .en(en), .scan_tick(scan_tick),
      .flicker_state(flicker_state), .screen_flicker_en(screen_flicker_en),
      .point_flicker_en(point_flicker_en), .point_flicker_pos(point_flicker_pos),
      .point_flicker_ch(point_flicker_ch), .chan_flicker_en(chan_flicker_en),
      .mem(mem_bus), .led_row(led_row), .led_col(led_col), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // reference model state: row being fetched, columns delivered so far, pending memory read
   int               frow, ndel, tick_cnt, tick_period, pend_cnt, pend_lat, data_mode, plan, ph_ticks;
   logic             pend, prev_tick, prev_acc, rand_patch;
   logic [RW+CW-1:0] pend_addr;
   logic [CH-1:0]    exp_sh [COLS];
   logic [ROWS-1:0]  exp_row;
   logic [CH*COLS-1:0] exp_col;
   logic             exp_und;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [CH-1:0] ref_patch(input logic [CH-1:0] d, input int r, input int c);
      logic [CH-1:0] v;
      v = d;
      if (screen_flicker_en) begin
         v    = {CH{~flicker_state}};
         v[0] = flicker_state;
      end
      else if (point_flicker_en && int'(point_flicker_pos) == r*COLS + c)
         v[point_flicker_ch] = flicker_state;
      else
         for (int k = 0; k < CH; k++) if (chan_flicker_en[k] && d[k]) v[k] = flicker_state;
      return v;
   endfunction

   function automatic logic [CH-1:0] mem_pixel(input int r, input int c);
      logic [CH-1:0] p;
      case (data_mode)
         0:       p = CH'({r[0], c[0]});
         1:       p = '1;
         default: p = CH'($urandom);
      endcase
      return p;
   endfunction

   task automatic model_reset();
      frow = 0; ndel = 0; pend = 1'b0; prev_tick = 1'b0; prev_acc = 1'b0; tick_cnt = 0;
   endtask

   task automatic cycle();
      logic          tick, vld, junk, acc;
      logic [CH-1:0] d;
      int            r, c;
      @(negedge clk);
      if (prev_tick) begin
         ph_ticks++;
         chk("led_row", led_row, exp_row);
         chk("led_col", led_col, exp_col);
         chk("underrun", underrun, exp_und);
         if (ph_ticks >= 2) begin
            case (plan)
               2: chk("plan2_blank", led_col, 16'h0000);
               4: chk("plan4_point", led_col, (exp_row == 8'h04) ? 16'hDFFF : 16'hFFFF);
               5: chk("plan5_chan", led_col, 16'hFF00);
               default: ;
            endcase
         end
      end
      else
         chk("underrun_idle", underrun, 1'b0);
      if (prev_acc || ndel == COLS) chk("mem_en_off", mem_bus.mem_en, 1'b0);
      if (mem_bus.mem_en) chk("mem_addr", mem_bus.mem_addr, frow*COLS + ndel);

      tick = 1'b0;
      if (tick_period > 0) begin
         tick_cnt++;
         if (tick_cnt >= tick_period) begin
            tick = 1'b1;
            tick_cnt = 0;
         end
      end
      if (rand_patch) begin
         flicker_state     = 1'($urandom);
         screen_flicker_en = ($urandom % 8) == 0;
         point_flicker_en  = 1'($urandom);
         point_flicker_pos = ($urandom % 2 == 0) ? mem_bus.mem_addr : (RW+CW)'($urandom);
         point_flicker_ch  = PCW'($urandom);
         chan_flicker_en   = CH'($urandom);
      end

      vld = 1'b0; junk = 1'b0;
      if (!mem_bus.mem_en || (pend && mem_bus.mem_addr != pend_addr)) pend = 1'b0;
      if (mem_bus.mem_en) begin
         if (!pend) begin
            pend      = 1'b1;
            pend_addr = mem_bus.mem_addr;
            pend_cnt  = 0;
            pend_lat  = (data_mode == 2) ? int'($urandom_range(1, 4)) : LAT;
         end
         pend_cnt++;
         if (pend_cnt >= pend_lat) begin
            vld  = 1'b1;
            pend = 1'b0;
         end
      end
      else if (data_mode == 2)
         junk = 1'($urandom);

      r = int'(mem_bus.mem_addr) / COLS;
      c = int'(mem_bus.mem_addr) % COLS;
      d = vld ? mem_pixel(r, c) : CH'($urandom);
      acc = vld && !tick;
      if (acc) begin
         exp_sh[c] = ref_patch(d, r, c);
         ndel++;
      end
      if (tick) begin
         exp_row       = '0;
         exp_row[frow] = 1'b1;
         exp_und       = (ndel != COLS);
         exp_col       = '0;
         if (!exp_und)
            for (int cc = 0; cc < COLS; cc++)
               for (int k = 0; k < CH; k++) exp_col[k*COLS + cc] = exp_sh[cc][k];
         frow = (frow + 1) % ROWS;
         ndel = 0;
         if (data_mode == 2) tick_period = $urandom_range(8, 45);
      end
      scan_tick          = tick;
      mem_bus.mem_valid  = vld | junk;
      mem_bus.mem_data   = d;
      prev_tick = tick;
      prev_acc  = acc;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_fetch(input string tag);
      int n;
      n = 0;
      while (!mem_bus.mem_en && n < 60) begin
         cycle();
         n++;
      end
      chk(tag, mem_bus.mem_en, 1'b1);
   endtask

   task automatic set_patch(input logic fs, input logic scr, input logic pt, input logic [CH-1:0] cm);
      flicker_state = fs; screen_flicker_en = scr; point_flicker_en = pt; chan_flicker_en = cm;
   endtask

   task automatic quiet_inputs();
      scan_tick = 1'b0; mem_bus.mem_valid = 1'b0; mem_bus.mem_data = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n_ = 1'b0; en = 1'b1; quiet_inputs();
      set_patch(1'b0, 1'b0, 1'b0, '0);
      point_flicker_pos = '0; point_flicker_ch = '0;
      rand_patch = 1'b0; data_mode = 0; plan = 0; ph_ticks = 0; tick_period = 40;
      exp_row = '0; exp_col = '0; exp_und = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_led_row", led_row, '0);
      chk("rst_led_col", led_col, '0);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_mem_en", mem_bus.mem_en, 1'b0);
      rst_n_ = 1'b1;
      model_reset();

      // steady scanning, rows complete in time
      run(ROWS * 40 + 40);
      // ticks too fast: every row underruns
      plan = 2; ph_ticks = 0; tick_period = 10;
      run(100);
      // whole-screen flicker
      plan = 0; tick_period = 40;
      set_patch(1'b1, 1'b1, 1'b0, '0);
      run(120);
      chk("screen_fs1", led_col, 16'h00FF);
      flicker_state = 1'b0;
      run(120);
      chk("screen_fs0", led_col, 16'hFF00);
      // single-pixel flicker on row 2 column 5, channel 1
      data_mode = 1; plan = 4; ph_ticks = 0;
      set_patch(1'b0, 1'b0, 1'b1, '0);
      point_flicker_pos = 6'(2*COLS + 5); point_flicker_ch = 1'b1;
      run((ROWS + 2) * 40);
      // channel-0 flicker mask
      plan = 5; ph_ticks = 0;
      set_patch(1'b0, 1'b0, 1'b0, 2'b01);
      run(160);
      plan = 0;

      // asynchronous reset while a fetch is outstanding
      wait_fetch("pre_rst_fetch");
      rst_n_ = 1'b0; quiet_inputs();
      #1;
      chk("arst_mem_en", mem_bus.mem_en, 1'b0);
      chk("arst_led_row", led_row, '0);
      chk("arst_led_col", led_col, '0);
      chk("arst_underrun", underrun, 1'b0);
      @(negedge clk);
      rst_n_ = 1'b1;
      model_reset();
      wait_fetch("arst_refetch");
      chk("arst_first_addr", mem_bus.mem_addr, '0);

      // synchronous return to reset through en
      run(45);
      wait_fetch("pre_en_fetch");
      en = 1'b0; quiet_inputs();
      #1;
      chk("en_still_on", mem_bus.mem_en, 1'b1);
      @(negedge clk);
      chk("en_mem_en", mem_bus.mem_en, 1'b0);
      chk("en_led_row", led_row, '0);
      chk("en_led_col", led_col, '0);
      chk("en_underrun", underrun, 1'b0);
      en = 1'b1;
      model_reset();
      wait_fetch("en_refetch");
      chk("en_first_addr", mem_bus.mem_addr, '0);

      // fully randomised traffic, latencies, tick spacing and patch inputs
      data_mode = 2; rand_patch = 1'b1; tick_period = 30;
      run(6000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/display_matrix_scanner.md
Name: display_matrix_scanner

Overview:
Parametrised LED-matrix scan engine driving an ROWS x COLS matrix with CH colour channels per pixel.
- Prefetches the next row from frame memory over a req/valid handshake into a shadow buffer, and swaps it onto the column drivers on each scan tick.
- Applies screen/point/channel flicker patches during the fetch.
- Blanks the columns and flags underrun when a fetch has not completed in time.
- Sits between the frame-memory arbiter and the board LED pins.

Parameters:
- ROWS, 8, matrix rows (>=2, power of 2).
- COLS, 8, matrix columns (>=2, power of 2).
- CH, 2, colour channels per pixel (>=1).
- RW, $clog2(ROWS), row index width (derived, do not override).
- CW, $clog2(COLS), column index width (derived, do not override).

Ports:
- clk  in  1  system clock.
- rst_n_  in  1  reset, asynchronous, active-low.
- en  in  1  block enable; low = synchronous return to reset state.
- scan_tick  in  1  one-cycle strobe, advance displayed row.
- flicker_state  in  1  current flicker phase.
- screen_flicker_en  in  1  whole-screen flicker.
- point_flicker_en  in  1  single-pixel flicker.
- point_flicker_pos  in  RW+CW  {row,col} of flickering pixel.
- point_flicker_ch  in  max(1,$clog2(CH))  channel used for point flicker.
- chan_flicker_en  in  CH  per-channel flicker mask.
- mem_en  out  1  read request.
- mem_addr  out  RW+CW  {fetch_row, col_i}.
- mem_valid  in  1  read data valid, 1 cycle.
- mem_data  in  CH  pixel bits; bit k = channel k.
- led_row  out  ROWS  one-hot active-high row select.
- led_col  out  CH*COLS  column drive; led_col[k*COLS+c] = channel k, column c.
- underrun  out  1  one-cycle pulse, row shown blank.

Behaviour:
- Reset (async rst_n_ low, or en low at a clk edge):
  - led_row=0, led_col=0, underrun=0, mem_en=0.
  - disp_row=ROWS-1, fetch_row=0, col_i=0, shadow=0, state=FETCH.
- FSM states FETCH, GAP, DONE:
  - FETCH: mem_en=1, mem_addr={fetch_row,col_i} held stable until mem_valid.
    - On mem_valid, store the patched bits at shadow column col_i.
    - col_i==COLS-1 -> DONE, col_i=0; else col_i+1 -> GAP.
  - GAP: mem_en=0 for exactly one cycle -> FETCH.
  - DONE: mem_en=0; idle until scan_tick.
- mem_valid while mem_en=0 is ignored.
- Request rate: at most one request per 2 cycles; fetch latency >= 2*COLS cycles.
- scan_tick (any state), registered outputs update next edge:
  - disp_row <= fetch_row; led_row <= one-hot(fetch_row).
  - If state==DONE: led_col <= patched shadow, underrun=0.
  - Else: led_col <= 0 and underrun=1 for 1 cycle; the partial fetch is aborted, and any mem_valid in the tick cycle is dropped.
  - fetch_row <= fetch_row+1, wrapping ROWS-1 -> 0. col_i=0, shadow=0, state=FETCH.
- First tick after reset shows row 0. Display order 0,1,...,ROWS-1,0.
- Patch applied to mem_data at store time; priority is screen > point > channel.
  - Screen: channel 0 = flicker_state, channels 1..CH-1 = ~flicker_state. The memory value is ignored.
  - Point: if {fetch_row,col_i}==point_flicker_pos, channel point_flicker_ch = flicker_state. Other channels unchanged.
  - Channel: for each k with chan_flicker_en[k]=1 and mem_data[k]=1, bit = flicker_state. A 0 stays 0.
  - Patch inputs are sampled at the store cycle only.
- Widths: all counters wrap modulo their width. No arithmetic overflow is visible on ports.

Test Plan:
1. Default params, memory returns pixel(r,c)={r[0],c[0]} after 3-cycle latency; ticks every 40 cycles. Required: led_row steps 01,02,...,80,01; led_col matches row r-1 data; underrun never asserted.
2. Same setup, ticks every 10 cycles (< 2*COLS). Required: underrun pulses every tick; led_col=0; mem_en drops and restarts at col 0 of the next row.
3. screen_flicker_en=1, flicker_state=1. Required: after the next full row, led_col[7:0]=FF and led_col[15:8]=00. With flicker_state=0, the values invert.
4. point_flicker_en=1, pos={3'd2,3'd5}, ch=1, flicker_state=0, memory all 1s. Required: row 2 shows green bit5=0; all other bits =1.
5. chan_flicker_en=2'b01, flicker_state=0, memory 2'b11 everywhere. Required: channel 0 columns 0, channel 1 columns FF.
6. Deassert rst_n_ (and separately en) mid-FETCH with mem_en=1. Required: mem_en=0, led_row=0, led_col=0 immediately (rst_n_) or next edge (en). After release, the first fetch targets addr 0.
